// File: rtl/isp_stat_awb_zone.sv
// isp_stat_awb_zone
// Per-zone auto-white-balance statistics. Each valid in-window pixel (all three
// components inside [min,max]) adds 1 to its zone's count and its R/G/B values
// to the zone's sums. Two banks are kept: one accumulates the current frame and
// the other holds the last completed frame for readout. At the end of an armed
// frame the banks swap and out_done pulses.
//
// Ports
//   pclk, rst            clock, synchronous active-high reset
//   min, max             inclusive valid range applied to R, G and B
//   in_href, in_vsync    active-pixel qualifier, vertical blanking flag
//   in_r, in_g, in_b     pixel components
//   out_done             one-cycle pulse: new frame results readable
//   out_frame_id         completed-frame counter (wraps)
//   rd_en/rd_zone/rd_sel readout request (sel: 0 cnt, 1 sum_r, 2 sum_g, 3 sum_b)
//   rd_valid/rd_data     readout response, one cycle after rd_en
// OUT_BITS is expected to be at least BITS.
module isp_stat_awb_zone #(
    parameter int BITS     = 8,
    parameter int WIDTH    = 1280,
    parameter int HEIGHT   = 960,
    parameter int ZONES_X  = 4,
    parameter int ZONES_Y  = 4,
    parameter int OUT_BITS = 32,
    localparam int NZ      = ZONES_X * ZONES_Y,
    localparam int ZBITS   = (NZ > 1) ? $clog2(NZ) : 1
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic [BITS-1:0]     min,
    input  logic [BITS-1:0]     max,
    input  logic                in_href,
    input  logic                in_vsync,
    input  logic [BITS-1:0]     in_r,
    input  logic [BITS-1:0]     in_g,
    input  logic [BITS-1:0]     in_b,
    output logic                out_done,
    output logic [7:0]          out_frame_id,
    input  logic                rd_en,
    input  logic [ZBITS-1:0]    rd_zone,
    input  logic [1:0]          rd_sel,
    output logic                rd_valid,
    output logic [OUT_BITS-1:0] rd_data
);

    localparam int ZW = WIDTH / ZONES_X;
    localparam int ZH = HEIGHT / ZONES_Y;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam int XB = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
    localparam int YB = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;
    localparam int AW = ((OUT_BITS > BITS) ? OUT_BITS : BITS) + 1;

    // Registered inputs
    logic            href_q, vs_q, pix_ok_q;
    logic [BITS-1:0] r_q, g_q, b_q;
    logic            href_prev, vs_prev;

    // Position tracking
    logic [CW-1:0] col, xoff;
    logic [RW-1:0] row, yoff;
    logic [XB-1:0] zx;
    logic [YB-1:0] zy;

    // Control
    logic [1:0] fe_pipe;
    logic       armed;
    logic       act;

    logic [OUT_BITS-1:0] acc [2][NZ][4];

    logic             frame_start, frame_end, line_end, in_win;
    logic [ZBITS-1:0] zone_idx;

    assign frame_start = vs_prev & ~vs_q;
    assign frame_end   = vs_q & ~vs_prev;
    assign line_end    = href_prev & ~href_q;
    assign in_win      = href_q && (col < CW'(WIDTH)) && (row < RW'(HEIGHT));
    assign zone_idx    = ZBITS'(int'(zy) * ZONES_X + int'(zx));

    function automatic logic [OUT_BITS-1:0] sat_add(input logic [OUT_BITS-1:0] a,
                                                    input logic [BITS-1:0] b);
        logic [AW-1:0] s;
        s = AW'(a) + AW'(b);
        return (s > AW'({OUT_BITS{1'b1}})) ? {OUT_BITS{1'b1}} : s[OUT_BITS-1:0];
    endfunction

    always_ff @(posedge pclk) begin
        if (rst) begin
            href_q   <= 1'b0;
            vs_q     <= 1'b0;
            pix_ok_q <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            href_q   <= in_href;
            vs_q     <= in_vsync;
            r_q      <= in_r;
            g_q      <= in_g;
            b_q      <= in_b;
            // min > max naturally fails every component test
            pix_ok_q <= (in_r >= min) && (in_r <= max) &&
                        (in_g >= min) && (in_g <= max) &&
                        (in_b >= min) && (in_b <= max);
        end
    end

    // Zone coordinates advance alongside the pixel counters. The last zone in
    // each direction never advances, so it absorbs any remainder.
    always_ff @(posedge pclk) begin
        if (rst) begin
            href_prev <= 1'b0;
            vs_prev   <= 1'b0;
            col       <= '0;
            xoff      <= '0;
            zx        <= '0;
            row       <= '0;
            yoff      <= '0;
            zy        <= '0;
        end else begin
            href_prev <= href_q;
            vs_prev   <= vs_q;
            if (!href_q) begin
                col  <= '0;
                xoff <= '0;
                zx   <= '0;
            end else if (col < CW'(WIDTH)) begin
                col <= col + 1'b1;
                if (zx != XB'(ZONES_X - 1)) begin
                    if (xoff == CW'(ZW - 1)) begin
                        zx   <= zx + 1'b1;
                        xoff <= '0;
                    end else begin
                        xoff <= xoff + 1'b1;
                    end
                end
            end
            if (frame_start) begin
                row  <= '0;
                yoff <= '0;
                zy   <= '0;
            end else if (line_end && (row < RW'(HEIGHT))) begin
                row <= row + 1'b1;
                if (zy != YB'(ZONES_Y - 1)) begin
                    if (yoff == RW'(ZH - 1)) begin
                        zy   <= zy + 1'b1;
                        yoff <= '0;
                    end else begin
                        yoff <= yoff + 1'b1;
                    end
                end
            end
        end
    end

    // The swap is delayed two cycles past frame_end so it lands together with
    // out_done; reads issued before the pulse still see the previous frame.
    always_ff @(posedge pclk) begin
        if (rst) begin
            fe_pipe      <= '0;
            armed        <= 1'b0;
            act          <= 1'b0;
            out_done     <= 1'b0;
            out_frame_id <= '0;
        end else begin
            fe_pipe  <= {fe_pipe[0], frame_end};
            out_done <= fe_pipe[1] & armed;
            if (frame_start)
                armed <= 1'b1;
            if (fe_pipe[1] && armed) begin
                act          <= ~act;
                out_frame_id <= out_frame_id + 8'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int z = 0; z < NZ; z++)
                    for (int s = 0; s < 4; s++)
                        acc[b][z][s] <= '0;
        end else if (frame_start) begin
            for (int z = 0; z < NZ; z++)
                for (int s = 0; s < 4; s++)
                    acc[act][z][s] <= '0;
        end else if (in_win && pix_ok_q) begin
            acc[act][zone_idx][0] <= sat_add(acc[act][zone_idx][0], BITS'(1));
            acc[act][zone_idx][1] <= sat_add(acc[act][zone_idx][1], r_q);
            acc[act][zone_idx][2] <= sat_add(acc[act][zone_idx][2], g_q);
            acc[act][zone_idx][3] <= sat_add(acc[act][zone_idx][3], b_q);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= (int'(rd_zone) < NZ) ? acc[~act][rd_zone][rd_sel] : '0;
        end
    end

endmodule
